ifetch_prefetch: RTL and testbench

Parametrised next-generation fetch stage. It issues sequential PC requests to an icache with variable latency over a req/gnt plus response-valid handshake, and buffers returned instructions with their PCs in a FIFO_DEPTH-deep prefetch queue. It feeds decode over a valid/ready handshake. An EXE redirect (flush) kills queued and in-flight fetches, and fetching restarts at the target PC.

---
 rtl/ifetch_prefetch.sv | 129 ++++++++++++
 tb/tb_ifetch_prefetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Sequential instruction fetch with an in-order icache tag FIFO and a prefetch queue to decode.
// Redirects kill queued entries and count outstanding responses to drop.
module ifetch_prefetch #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] reset_adr_i,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_adr_o,
    input  logic            icache_gnt_i,
    input  logic            icache_rsp_v_i,
    input  logic [ILEN-1:0] icache_instr_i,
    input  logic            flush_v_i,
    input  logic [XLEN-1:0] pc_data_q_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [ILEN-1:0] instr_q_o,
    output logic [XLEN-1:0] pc_q_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StBoot, StFetch, StFull} state_e;

    state_e state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, tag_wr_q, tag_rd_q;

    logic [ILEN-1:0] instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] tag_mem   [FIFO_DEPTH];

    logic [CW:0] used;
    logic credit_ok, flush, accept, rsp_take, push, pop;

    // Credits cover both queued entries and responses still owed by the icache.
    assign used      = {1'b0, in_flight_q} + {1'b0, count_q};
    assign credit_ok = used < DepthW;
    assign flush     = flush_v_i && (state_q != StBoot);

    assign icache_req_o = (state_q == StFetch) && credit_ok && !flush_v_i && !reset;
    assign icache_adr_o = fetch_pc_q;
    assign accept       = icache_req_o && icache_gnt_i;
    assign rsp_take     = icache_rsp_v_i && (in_flight_q != '0);
    assign push         = rsp_take && (drop_q == '0) && !flush && !reset;
    assign pop          = dec_valid_o && dec_ready_i;

    assign dec_valid_o = (count_q != '0) && !reset;
    assign instr_q_o   = dec_valid_o ? instr_mem[rd_ptr_q] : '0;
    assign pc_q_o      = dec_valid_o ? pc_mem[rd_ptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            StBoot: begin
                state_d    = StFetch;
                fetch_pc_d = reset_adr_i;
            end
            StFetch: if (!credit_ok) state_d = StFull;
            StFull:  if (credit_ok) state_d = StFetch;
            default: state_d = StBoot;
        endcase
        if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        if (flush) begin
            fetch_pc_d = pc_data_q_i;
            state_d    = StFetch;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q + CW'(accept) - CW'(rsp_take);
        drop_d      = drop_q;
        if (icache_rsp_v_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
        // Everything still outstanding after this cycle belongs to the old path.
        if (flush) drop_d = in_flight_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBoot;
            fetch_pc_q  <= '0;
            in_flight_q <= '0;
            drop_q      <= in_flight_d;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
            if (accept)   tag_wr_q <= tag_wr_q + 1'b1;
            if (rsp_take) tag_rd_q <= tag_rd_q + 1'b1;
            if (flush) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wr_q] <= fetch_pc_q;
        if (push) begin
            instr_mem[wr_ptr_q] <= icache_instr_i;
            pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
        end
    end

    queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == DepthC)));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: an in-order icache model with programmable latency feeds a
// scoreboard of expected {pc, instr} pairs that is checked against the decode head.
module tb_ifetch_prefetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reset_adr;
    logic        req;
    logic [31:0] adr;
    logic        gnt;
    logic        rsp_v;
    logic [31:0] rsp_instr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    ifetch_prefetch dut (
        .clk           (clk),
        .reset         (reset),
        .reset_adr_i   (reset_adr),
        .icache_req_o  (req),
        .icache_adr_o  (adr),
        .icache_gnt_i  (gnt),
        .icache_rsp_v_i(rsp_v),
        .icache_instr_i(rsp_instr),
        .flush_v_i     (flush),
        .pc_data_q_i   (flush_pc),
        .dec_valid_o   (dec_valid),
        .dec_ready_i   (dec_ready),
        .instr_q_o     (instr_q),
        .pc_q_o        (pc_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int unsigned due;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_pc;
    int unsigned cyc;
    int unsigned lat;
    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned n_pop;
    int unsigned n_gnt;
    logic        s_req, s_valid;
    logic [31:0] s_adr, s_pc, s_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // One clock cycle: present the icache response, sample at negedge, update the model.
    task automatic tick();
        if (!reset && pending.size() > 0 && pending[0].due <= cyc) begin
            rsp_v     = 1'b1;
            rsp_instr = instr_of(pending[0].pc);
        end else begin
            rsp_v     = 1'b0;
            rsp_instr = '0;
        end
        @(negedge clk);
        s_req   = req;
        s_adr   = adr;
        s_valid = dec_valid;
        s_pc    = pc_q;
        s_instr = instr_q;
        if (!reset) begin
            if (s_valid) begin
                if (exp_q.size() == 0) begin
                    check("dec_spurious", 32'(s_valid), 32'd0);
                end else begin
                    check("dec_pc", s_pc, exp_q[0]);
                    check("dec_instr", s_instr, instr_of(exp_q[0]));
                    if (dec_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (s_req) check("req_adr", s_adr, exp_req_pc);
            if (rsp_v) void'(pending.pop_front());
            if (flush) begin
                check("flush_req", 32'(s_req), 32'd0);
                exp_q.delete();
                exp_req_pc = flush_pc;
            end else if (s_req && gnt) begin
                pending.push_back('{pc: exp_req_pc, due: cyc + lat});
                exp_q.push_back(exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
                n_gnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        reset = 1'b1;
        flush = 1'b0;
        gnt   = 1'b1;
        pending.delete();
        exp_q.delete();
        repeat (3) tick();
        check("rst_req", 32'(s_req), 32'd0);
        check("rst_adr", s_adr, 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_instr", s_instr, 32'd0);
        check("rst_pc", s_pc, 32'd0);
        reset_adr  = boot;
        exp_req_pc = boot;
        reset      = 1'b0;
        tick();
        check("boot_noreq", 32'(s_req), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        reset_adr = '0;
        gnt       = 1'b1;
        rsp_v     = 1'b0;
        rsp_instr = '0;
        flush     = 1'b0;
        flush_pc  = '0;
        dec_ready = 1'b1;
        cyc = 0; lat = 1; n_chk = 0; n_pass = 0; n_pop = 0; n_gnt = 0;

        // Boot and full-rate streaming.
        do_reset(32'h8000_0000);
        tick();
        check("boot_req", 32'(s_req), 32'd1);
        check("boot_adr", s_adr, 32'h8000_0000);
        n_pop = 0;
        tick();
        tick();
        check("boot_pc0", s_pc, 32'h8000_0000);
        tick();
        check("boot_pc1", s_pc, 32'h8000_0004);
        tick();
        check("boot_pc2", s_pc, 32'h8000_0008);
        repeat (7) tick();
        check("boot_rate", n_pop, 32'd10);

        // Grant stall holds the request.
        gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", 32'(s_req), 32'd1);
            check("stall_adr", s_adr, exp_req_pc);
        end
        gnt = 1'b1;
        repeat (6) tick();

        // Flush coinciding with a grant and a response.
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        tick();
        check("sc_rsp_seen", 32'(rsp_v), 32'd1);
        flush = 1'b0;
        tick();
        check("sc_next_req", 32'(s_req), 32'd1);
        check("sc_next_adr", s_adr, 32'h0000_0100);
        check("sc_cleared", 32'(s_valid), 32'd0);
        tick();
        tick();
        check("sc_valid", 32'(s_valid), 32'd1);
        check("sc_pc", s_pc, 32'h0000_0100);
        repeat (4) tick();

        // Flush with three requests outstanding at latency 3.
        lat = 3;
        do_reset(32'h0000_2000);
        n_gnt = 0;
        repeat (3) tick();
        check("fl_gnts", n_gnt, 32'd3);
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        tick();
        flush = 1'b0;
        begin
            int w = 0;
            do begin
                tick();
                w++;
            end while (!s_valid && w < 20);
        end
        check("fl_valid", 32'(s_valid), 32'd1);
        check("fl_pc", s_pc, 32'h0000_0100);
        check("fl_instr", s_instr, instr_of(32'h0000_0100));
        repeat (8) tick();

        // Backpressure: credits limit outstanding work to the queue depth.
        lat       = 2;
        dec_ready = 1'b0;
        do_reset(32'h0000_4000);
        n_gnt = 0;
        repeat (10) tick();
        check("bp_gnts", n_gnt, 32'd4);
        check("bp_full", 32'(s_req), 32'd0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        n_gnt = 0;
        repeat (6) tick();
        check("bp_one_more", n_gnt, 32'd1);
        check("bp_full2", 32'(s_req), 32'd0);
        dec_ready = 1'b1;
        repeat (10) tick();

        // PC wrap-around.
        lat = 1;
        do_reset(32'hFFFF_FFFC);
        tick();
        check("wrap_adr0", s_adr, 32'hFFFF_FFFC);
        tick();
        check("wrap_adr1", s_adr, 32'h0000_0000);
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
